// File: rtl/vga_scan_timing.sv
// Raster scan generator: H/V counters for the pixel sources, plus sync/blank
// delayed to line up with the source pipeline before the registered VGA pins.
module vga_scan_timing #(
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter bit          SYNC_ACTIVE   = 1'b0,
    parameter int unsigned PIXEL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    output logic [10:0] PIXEL_H,
    output logic [10:0] PIXEL_V,
    output logic        video_on,
    output logic        frame_start,
    input  logic [2:0]  PIXEL,
    output logic [2:0]  vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    localparam int unsigned CW       = 11;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    // Stages ahead of the output register; the output register is the last stage.
    localparam int unsigned DLY      = (PIXEL_LATENCY > 1) ? PIXEL_LATENCY - 1 : 1;

    if (H_TOTAL > 2048 || V_TOTAL > 2048 || PIXEL_LATENCY < 1 || PIXEL_LATENCY > 4)
    begin : g_bad_param
        $error("vga_scan_timing: illegal geometry or PIXEL_LATENCY");
    end

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic          r_video_on;
    logic          r_frame_start;
    logic [2:0]    r_dly [DLY];
    logic [2:0]    r_rgb;
    logic          r_hsync;
    logic          r_vsync;

    logic          w_h_last;
    logic          w_v_last;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_vis;
    logic          w_vis_next;
    logic          w_hs;
    logic          w_vs;
    logic [2:0]    w_raw;
    logic [2:0]    w_last;

    // Next counter values; line advances on the same tick the column wraps.
    always_comb begin
        w_h_last = (r_h_cnt == CW'(H_TOTAL - 1));
        w_v_last = (r_v_cnt == CW'(V_TOTAL - 1));
        w_h_next = w_h_last ? '0 : r_h_cnt + CW'(1);
        w_v_next = r_v_cnt;
        if (w_h_last) begin
            w_v_next = w_v_last ? '0 : r_v_cnt + CW'(1);
        end
    end

    assign w_vis      = (r_h_cnt < CW'(H_VISIBLE)) && (r_v_cnt < CW'(V_VISIBLE));
    assign w_vis_next = (w_h_next < CW'(H_VISIBLE)) && (w_v_next < CW'(V_VISIBLE));
    assign w_hs       = (r_h_cnt >= CW'(HS_START)) && (r_h_cnt <= CW'(HS_END));
    assign w_vs       = (r_v_cnt >= CW'(VS_START)) && (r_v_cnt <= CW'(VS_END));

    // {vis, hs, vs} as seen by the output register
    assign w_raw  = {w_vis, w_hs, w_vs};
    assign w_last = (PIXEL_LATENCY == 1) ? w_raw : r_dly[DLY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
            for (int unsigned i = 0; i < DLY; i++) begin
                r_dly[i] <= 3'b000;
            end
            r_rgb   <= 3'b000;
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
        end else begin
            r_frame_start <= 1'b0;
            if (pix_ce) begin
                r_h_cnt       <= w_h_next;
                r_v_cnt       <= w_v_next;
                r_video_on    <= w_vis_next;
                r_frame_start <= w_h_last && w_v_last;
                r_dly[0]      <= w_raw;
                for (int unsigned i = 1; i < DLY; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
                r_rgb   <= w_last[2] ? PIXEL : 3'b000;
                r_hsync <= w_last[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                r_vsync <= w_last[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end

    assign PIXEL_H     = r_h_cnt;
    assign PIXEL_V     = r_v_cnt;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;
    assign vga_rgb     = r_rgb;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: default 640x480 at latency 1 and 3, and a
// tiny 16x10 raster so whole frames fit in a short run.
module tb_vga_scan_timing;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic [2:0]  pixel;

    logic [10:0] a_h, a_v, b_h, b_v, s_h, s_v;
    logic        a_von, a_fs, a_hs, a_vs;
    logic        b_von, b_fs, b_hs, b_vs;
    logic        s_von, s_fs, s_hs, s_vs;
    logic [2:0]  a_rgb, b_rgb, s_rgb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_scan_timing u_a (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .PIXEL_H(a_h), .PIXEL_V(a_v), .video_on(a_von), .frame_start(a_fs),
        .PIXEL(pixel), .vga_rgb(a_rgb), .vga_hsync(a_hs), .vga_vsync(a_vs)
    );

    vga_scan_timing #(.PIXEL_LATENCY(3)) u_b (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .PIXEL_H(b_h), .PIXEL_V(b_v), .video_on(b_von), .frame_start(b_fs),
        .PIXEL(pixel), .vga_rgb(b_rgb), .vga_hsync(b_hs), .vga_vsync(b_vs)
    );

    // 16 x 10 raster: hsync on h 10..12, vsync on lines 7..8
    vga_scan_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_s (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .PIXEL_H(s_h), .PIXEL_V(s_v), .video_on(s_von), .frame_start(s_fs),
        .PIXEL(pixel), .vga_rgb(s_rgb), .vga_hsync(s_hs), .vga_vsync(s_vs)
    );

    // Reference model: src is the tick index whose counters the outputs show.
    function automatic logic [2:0] m_rgb(int src, int htot, int vtot, int hvis, int vvis,
                                         logic [2:0] pix);
        int h, v;
        if (src < 0) return 3'b000;
        h = src % htot;
        v = (src / htot) % vtot;
        return (h < hvis && v < vvis) ? pix : 3'b000;
    endfunction

    function automatic logic m_hsync(int src, int htot, int hs0, int hsw);
        int h;
        if (src < 0) return 1'b1;
        h = src % htot;
        return (h >= hs0 && h < hs0 + hsw) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic m_vsync(int src, int htot, int vtot, int vs0, int vsw);
        int v;
        if (src < 0) return 1'b1;
        v = (src / htot) % vtot;
        return (v >= vs0 && v < vs0 + vsw) ? 1'b0 : 1'b1;
    endfunction

    task automatic clk_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        pix_ce = 1'b1;
        clk_cycle();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        pixel  = 3'b101;
        reset  = 1'b1;
        pix_ce = 1'b1;
        clk_cycle();
        clk_cycle();
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (a_h !== 11'd0 || a_v !== 11'd0) begin n_err++; $display("FAIL reset_hv: got %0d/%0d expected 0/0", a_h, a_v); end
            n_vec++; if (a_von !== 1'b0 || a_fs !== 1'b0) begin n_err++; $display("FAIL reset_von_fs: got %b/%b expected 0/0", a_von, a_fs); end
            n_vec++; if (a_rgb !== 3'b000 || b_rgb !== 3'b000 || s_rgb !== 3'b000) begin n_err++; $display("FAIL reset_rgb: got %b/%b/%b expected 000", a_rgb, b_rgb, s_rgb); end
            n_vec++; if (a_hs !== 1'b1 || a_vs !== 1'b1 || b_hs !== 1'b1 || s_vs !== 1'b1) begin n_err++; $display("FAIL reset_sync: got %b%b%b%b expected 1111", a_hs, a_vs, b_hs, s_vs); end
            pix_ce = 1'b0;
            clk_cycle();
        end
    endtask

    task automatic test_scan();
        int eh, ev;
        do_reset();
        pixel = 3'b000;
        for (int t = 1; t <= 1700; t++) begin
            clk_cycle();
            eh = t % 800;
            ev = t / 800;
            n_vec++; if (a_h !== 11'(eh) || a_v !== 11'(ev)) begin n_err++; $display("FAIL scan_hv t=%0d: got %0d/%0d expected %0d/%0d", t, a_h, a_v, eh, ev); end
            n_vec++; if (a_von !== 1'(eh < 640 && ev < 480)) begin n_err++; $display("FAIL scan_video_on t=%0d: got %b", t, a_von); end
            n_vec++; if (a_fs !== 1'b0) begin n_err++; $display("FAIL scan_fs t=%0d: got %b expected 0", t, a_fs); end
            n_vec++; if (s_h !== 11'(t % 16) || s_v !== 11'((t / 16) % 10)) begin n_err++; $display("FAIL scan_small_hv t=%0d: got %0d/%0d", t, s_h, s_v); end
            n_vec++; if (s_fs !== 1'(t % 160 == 0)) begin n_err++; $display("FAIL scan_small_fs t=%0d: got %b", t, s_fs); end
        end
    endtask

    task automatic test_hsync();
        int a_low = 0, a_first = -1, a_last = -1, b_first = -1;
        do_reset();
        pixel = 3'b111;
        for (int t = 1; t <= 1600; t++) begin
            clk_cycle();
            n_vec++; if (a_hs !== m_hsync(t - 1, 800, 656, 96)) begin n_err++; $display("FAIL hsync_l1 t=%0d: got %b", t, a_hs); end
            n_vec++; if (b_hs !== m_hsync(t - 3, 800, 656, 96)) begin n_err++; $display("FAIL hsync_l3 t=%0d: got %b", t, b_hs); end
            n_vec++; if (a_vs !== 1'b1) begin n_err++; $display("FAIL hsync_vs_idle t=%0d: got %b expected 1", t, a_vs); end
            if (t <= 800 && a_hs === 1'b0) begin
                a_low++;
                if (a_first < 0) a_first = t;
                a_last = t;
            end
            if (b_hs === 1'b0 && b_first < 0) b_first = t;
        end
        n_vec++; if (a_low != 96 || a_last - a_first + 1 != 96) begin n_err++; $display("FAIL hsync_width: got %0d low (span %0d) expected 96", a_low, a_last - a_first + 1); end
        n_vec++; if (a_first != 657) begin n_err++; $display("FAIL hsync_first_l1: got t=%0d expected 657", a_first); end
        n_vec++; if (b_first != 659) begin n_err++; $display("FAIL hsync_first_l3: got t=%0d expected 659", b_first); end
    endtask

    task automatic test_rgb();
        int a_cnt = 0, a_first = -1, b_first = -1;
        logic [2:0] pv;
        do_reset();
        for (int t = 1; t <= 2400; t++) begin
            pv = (t <= 1600) ? 3'b111 : 3'((t * 5) % 8);
            pixel = pv;
            clk_cycle();
            n_vec++; if (a_rgb !== m_rgb(t - 1, 800, 525, 640, 480, pv)) begin n_err++; $display("FAIL rgb_l1 t=%0d: got %b", t, a_rgb); end
            n_vec++; if (b_rgb !== m_rgb(t - 3, 800, 525, 640, 480, pv)) begin n_err++; $display("FAIL rgb_l3 t=%0d: got %b", t, b_rgb); end
            if (t <= 800 && a_rgb === 3'b111) a_cnt++;
            if (a_rgb === 3'b111 && a_first < 0) a_first = t;
            if (b_rgb === 3'b111 && b_first < 0) b_first = t;
        end
        n_vec++; if (a_cnt != 640) begin n_err++; $display("FAIL rgb_count: got %0d expected 640", a_cnt); end
        n_vec++; if (a_first != 1 || b_first != 3) begin n_err++; $display("FAIL rgb_first: got %0d/%0d expected 1/3", a_first, b_first); end
    endtask

    task automatic test_vsync();
        int low = 0, falls = 0, rises = 0, vis = 0;
        logic prev = 1'b1;
        do_reset();
        pixel = 3'b010;
        for (int t = 1; t <= 330; t++) begin
            clk_cycle();
            n_vec++; if (s_vs !== m_vsync(t - 1, 16, 10, 7, 2)) begin n_err++; $display("FAIL vsync t=%0d: got %b", t, s_vs); end
            n_vec++; if (s_hs !== m_hsync(t - 1, 16, 10, 3)) begin n_err++; $display("FAIL vsync_hs t=%0d: got %b", t, s_hs); end
            n_vec++; if (s_rgb !== m_rgb(t - 1, 16, 10, 8, 6, 3'b010)) begin n_err++; $display("FAIL vsync_rgb t=%0d: got %b", t, s_rgb); end
            if (t <= 160) begin
                if (s_vs === 1'b0) low++;
                if (prev === 1'b1 && s_vs === 1'b0) falls++;
                if (prev === 1'b0 && s_vs === 1'b1) rises++;
                if (s_rgb !== 3'b000) vis++;
            end
            prev = s_vs;
        end
        n_vec++; if (low != 32) begin n_err++; $display("FAIL vsync_width: got %0d expected 32", low); end
        n_vec++; if (falls != 1 || rises != 1) begin n_err++; $display("FAIL vsync_edges: got %0d/%0d expected 1/1", falls, rises); end
        n_vec++; if (vis != 48) begin n_err++; $display("FAIL vsync_vis_count: got %0d expected 48", vis); end
    endtask

    task automatic test_ce_toggle();
        int t = 0, n_fs = 0, fs_c0 = -1, fs_c1 = -1;
        logic ce;
        do_reset();
        pixel = 3'b110;
        for (int c = 1; c <= 700; c++) begin
            ce = (c % 2 == 1);
            pix_ce = ce;
            clk_cycle();
            if (ce) t++;
            n_vec++; if (s_h !== 11'(t % 16) || s_v !== 11'((t / 16) % 10)) begin n_err++; $display("FAIL ce_hv c=%0d: got %0d/%0d expected %0d/%0d", c, s_h, s_v, t % 16, (t / 16) % 10); end
            n_vec++; if (a_h !== 11'(t % 800)) begin n_err++; $display("FAIL ce_ah c=%0d: got %0d expected %0d", c, a_h, t % 800); end
            n_vec++; if (s_fs !== 1'(ce && t % 160 == 0)) begin n_err++; $display("FAIL ce_fs c=%0d: got %b", c, s_fs); end
            n_vec++; if (s_rgb !== m_rgb(t - 1, 16, 10, 8, 6, 3'b110) || s_hs !== m_hsync(t - 1, 16, 10, 3) || s_vs !== m_vsync(t - 1, 16, 10, 7, 2)) begin n_err++; $display("FAIL ce_outputs c=%0d: got rgb=%b hs=%b vs=%b", c, s_rgb, s_hs, s_vs); end
            if (s_fs === 1'b1) begin
                n_fs++;
                if (fs_c0 < 0) fs_c0 = c; else if (fs_c1 < 0) fs_c1 = c;
            end
        end
        n_vec++; if (n_fs != 2 || fs_c1 - fs_c0 != 320) begin n_err++; $display("FAIL ce_fs_period: got %0d pulses spacing %0d expected 2/320", n_fs, fs_c1 - fs_c0); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pixel = 3'b101;
        for (int t = 1; t <= 1100; t++) clk_cycle();
        n_vec++; if (a_h !== 11'd300 || a_v !== 11'd1) begin n_err++; $display("FAIL mid_pre_hv: got %0d/%0d expected 300/1", a_h, a_v); end
        n_vec++; if (a_rgb !== 3'b101 || s_vs !== 1'b0) begin n_err++; $display("FAIL mid_pre_out: got rgb=%b svs=%b expected 101/0", a_rgb, s_vs); end
        reset = 1'b1;
        clk_cycle();
        n_vec++; if (a_h !== 11'd0 || a_v !== 11'd0 || a_von !== 1'b0 || a_fs !== 1'b0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d/%0d von=%b fs=%b", a_h, a_v, a_von, a_fs); end
        n_vec++; if (a_rgb !== 3'b000 || b_rgb !== 3'b000 || a_hs !== 1'b1 || a_vs !== 1'b1 || s_vs !== 1'b1) begin n_err++; $display("FAIL mid_rst_out: got rgb=%b/%b hs=%b vs=%b svs=%b", a_rgb, b_rgb, a_hs, a_vs, s_vs); end
        reset = 1'b0;
        for (int t = 1; t <= 801; t++) begin
            clk_cycle();
            n_vec++; if (a_h !== 11'(t % 800) || a_v !== 11'(t / 800)) begin n_err++; $display("FAIL mid_hv t=%0d: got %0d/%0d", t, a_h, a_v); end
            n_vec++; if (a_rgb !== m_rgb(t - 1, 800, 525, 640, 480, 3'b101) || b_rgb !== m_rgb(t - 3, 800, 525, 640, 480, 3'b101)) begin n_err++; $display("FAIL mid_rgb t=%0d: got %b/%b", t, a_rgb, b_rgb); end
            n_vec++; if (a_hs !== m_hsync(t - 1, 800, 656, 96)) begin n_err++; $display("FAIL mid_hs t=%0d: got %b", t, a_hs); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        pix_ce = 1'b0;
        pixel  = 3'b000;
        @(negedge clk);
        test_reset();
        test_scan();
        test_hsync();
        test_rgb();
        test_vsync();
        test_ce_toggle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
